// File: rtl/dpwm_counter_cmp.sv
// dpwm_counter_cmp: counter-comparator DPWM core.
// Free-running WIDTH-bit counter with a double-buffered duty register that is
// reloaded only at the period wrap (or while idle). Every output is a flop.
// Optional complementary output with dead time: define DPWM_COMPL_EN.
module dpwm_counter_cmp #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DT    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm,
    output logic             period_end,
    output logic [WIDTH-1:0] cnt
`ifdef DPWM_COMPL_EN
    ,
    output logic             pwm_n
`endif
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // Dead time must leave at least the MAX cycle reachable for pwm_n.
    if (DT > (2 ** WIDTH) - 1) begin : g_dt_range
        $error("dpwm_counter_cmp: DT out of range");
    end

    logic             run;
    logic [WIDTH-1:0] d_act;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] d_act_next;
    logic             pwm_next;
    logic             period_end_next;

    // Next-state logic; outputs are decoded from the next counter/duty values
    // so the registered outputs line up with the registered counter.
    always_comb begin
        cnt_next        = '0;
        d_act_next      = d_act;
        if (en && run) begin
            cnt_next = cnt + WIDTH'(1);
        end
        if (!run || (cnt == MAX)) begin
            d_act_next = duty;
        end
        pwm_next        = en && (cnt_next < d_act_next);
        period_end_next = en && (cnt_next == MAX);
    end

    // Main state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run        <= 1'b0;
            cnt        <= '0;
            d_act      <= '0;
            pwm        <= 1'b0;
            period_end <= 1'b0;
        end else begin
            run        <= en;
            cnt        <= cnt_next;
            d_act      <= d_act_next;
            pwm        <= pwm_next;
            period_end <= period_end_next;
        end
    end

`ifdef DPWM_COMPL_EN
    logic [WIDTH:0] on_edge;
    logic           pwm_n_next;

    // Complementary turn-on point D+DT, one bit wider so an overflow past MAX
    // keeps pwm_n low for the whole period.
    always_comb begin
        on_edge    = {1'b0, d_act_next} + (WIDTH + 1)'(DT);
        pwm_n_next = en && ({1'b0, cnt_next} >= on_edge);
    end

    // Complementary output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_n <= 1'b0;
        end else begin
            pwm_n <= pwm_n_next;
        end
    end
`endif

endmodule

// File: tb/tb_dpwm_counter_cmp.sv
// Self-checking bench for dpwm_counter_cmp (WIDTH=4, DT=2).
// A period-level model tracks the position inside the current period and the
// duty latched for it; outputs are compared on every falling clock edge.
module tb_dpwm_counter_cmp;

    localparam int MAX   = 15;
    localparam int DT_TB = 2;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] duty;
    logic       pwm;
    logic       period_end;
    logic [3:0] cnt;
`ifdef DPWM_COMPL_EN
    logic       pwm_n;
`endif

    dpwm_counter_cmp #(.WIDTH(4), .DT(DT_TB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .duty       (duty),
        .pwm        (pwm),
        .period_end (period_end),
        .cnt        (cnt)
`ifdef DPWM_COMPL_EN
        ,
        .pwm_n      (pwm_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = position within the running period (-1 when idle),
    // dm = duty captured when that period started.
    int pos = -1;
    int dm  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    pos <= -1;
        else if (!en)                    pos <= -1;
        else if (pos < 0 || pos == MAX) begin
            pos <= 0;
            dm  <= int'(duty);
        end else                         pos <= pos + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cnt",        int'(cnt),        (pos < 0) ? 0 : pos);
            chk("pwm",        int'(pwm),        int'(pos >= 0 && pos < dm));
            chk("period_end", int'(period_end), int'(pos == MAX));
`ifdef DPWM_COMPL_EN
            chk("pwm_n",      int'(pwm_n),      int'(pos >= 0 && pos >= dm + DT_TB));
`endif
        end
    end

    task automatic run_cycles(input int n, output int hi, output int pe,
                              output int hn, output int ov);
        hi = 0; pe = 0; hn = 0; ov = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(pwm);
            pe += int'(period_end);
`ifdef DPWM_COMPL_EN
            hn += int'(pwm_n);
            ov += int'(pwm && pwm_n);
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int hi, pe, hn, ov;

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        duty    = 4'd0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_pe",  int'(period_end), 0);
        checking = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: duty 5 held, two full periods
        en   = 1'b1;
        duty = 4'd5;
        for (int p = 0; p < 2; p++) begin
            run_cycles(16, hi, pe, hn, ov);
            chk("t1_high", hi, 5);
            chk("t1_pe",   pe, 1);
        end
        chk("t1_end_cnt", int'(cnt), 15);
        chk("t1_end_pe",  int'(period_end), 1);

        // Test 2: duty 0 written at cnt==MAX, then duty 15
        duty = 4'd0;
        run_cycles(16, hi, pe, hn, ov);
        chk("t2_d0_high", hi, 0);
        chk("t2_d0_pe",   pe, 1);
        duty = 4'd15;
        run_cycles(16, hi, pe, hn, ov);
        chk("t2_d15_high", hi, 15);
        chk("t2_d15_last_pwm", int'(pwm), 0);

        // Test 3: duty 3 -> 12 changed at cnt 6
        duty = 4'd3;
        run_cycles(7, hi, pe, hn, ov);
        chk("t3_mid_cnt", int'(cnt), 6);
        duty = 4'd12;
        begin
            int hi2, pe2, hn2, ov2;
            run_cycles(9, hi2, pe2, hn2, ov2);
            chk("t3_cur_high", hi + hi2, 3);
        end
        run_cycles(16, hi, pe, hn, ov);
        chk("t3_next_high", hi, 12);

        // Test 4: en dropped at cnt 9, re-asserted 4 cycles later
        run_cycles(10, hi, pe, hn, ov);
        chk("t4_pre_cnt", int'(cnt), 9);
        en = 1'b0;
        @(negedge clk);
        chk("t4_off_pwm", int'(pwm), 0);
        chk("t4_off_cnt", int'(cnt), 0);
        chk("t4_off_pe",  int'(period_end), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        run_cycles(16, hi, pe, hn, ov);
        chk("t4_restart_high", hi, 12);
        chk("t4_restart_pe",   pe, 1);
        chk("t4_restart_cnt",  int'(cnt), 15);

        // Test 5: asynchronous reset pulse at cnt 4
        run_cycles(5, hi, pe, hn, ov);
        chk("t5_pre_cnt", int'(cnt), 4);
        chk("t5_pre_pwm", int'(pwm), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_cnt", int'(cnt), 0);
        chk("t5_async_pwm", int'(pwm), 0);
        chk("t5_async_pe",  int'(period_end), 0);
        #4 reset_n = 1'b1;
        @(negedge clk);
        run_cycles(16, hi, pe, hn, ov);
        chk("t5_resume_high", hi, 12);
        chk("t5_resume_pe",   pe, 1);

        // Test 6: duty 6 and 14 (complementary output when present)
        duty = 4'd6;
        run_cycles(16, hi, pe, hn, ov);
        chk("t6_d6_high", hi, 6);
`ifdef DPWM_COMPL_EN
        chk("t6_d6_high_n",  hn, 8);
        chk("t6_d6_overlap", ov, 0);
`endif
        duty = 4'd14;
        run_cycles(16, hi, pe, hn, ov);
        chk("t6_d14_high", hi, 14);
`ifdef DPWM_COMPL_EN
        chk("t6_d14_high_n", hn, 0);
`endif

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
